// File: rtl/ysyx_24090012_lsu.sv
// ysyx_24090012_lsu: load/store stage that issues one bus request per memory op, formats load data and hands results to the WBU.
module ysyx_24090012_lsu #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_WIDTH   = 64,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [31:0]           exu_inst,
  input  logic [DATA_WIDTH-1:0] exu_result,
  input  logic [DATA_WIDTH-1:0] exu_store_data,
  input  logic [31:0]           exu_next_pc,
  input  logic [NUM_WIDTH-1:0]  exu_num,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [31:0]           mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [3:0]            mem_req_wstrb,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  input  logic                  mem_resp_err,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [31:0]           lsu_to_wbu_inst,
  output logic [31:0]           next_pc,
  output logic [NUM_WIDTH-1:0]  num,
  output logic [31:0]           sim_lsu_addr,
  output logic                  lsu_fault
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [1:0]            state_q, state_d;
  logic [31:0]           inst_q, inst_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic [31:0]           npc_q, npc_d;
  logic [NUM_WIDTH-1:0]  num_q, num_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [31:0]           sim_q, sim_d;
  logic                  fault_q, fault_d;

  logic [6:0]            in_op;
  logic [2:0]            in_f3;
  logic                  in_load, in_store, in_mem, in_half, in_word, in_mis;
  logic [2:0]            q_f3;
  logic                  q_store;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] load_fmt;

  // Decode of the instruction currently offered by the EXU
  assign in_op    = exu_inst[6:0];
  assign in_f3    = exu_inst[14:12];
  assign in_load  = in_op == OP_LOAD;
  assign in_store = in_op == OP_STORE;
  assign in_mem   = in_load | in_store;
  assign in_half  = in_f3 == 3'b001 || (in_load && in_f3 == 3'b101);
  assign in_word  = in_f3 == 3'b010;
  assign in_mis   = ALIGN_CHECK && in_mem &&
                    ((in_half && exu_result[0]) || (in_word && exu_result[1:0] != 2'b00));

  // Decode of the captured instruction
  assign q_f3    = inst_q[14:12];
  assign q_store = inst_q[6:0] == OP_STORE;

  // Load lane extraction and sign/zero extension
  assign ld_byte  = mem_resp_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half  = addr_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
  assign load_fmt = q_f3 == 3'b000 ? {{24{ld_byte[7]}}, ld_byte} :
                    q_f3 == 3'b100 ? {24'b0, ld_byte} :
                    q_f3 == 3'b001 ? {{16{ld_half[15]}}, ld_half} :
                    q_f3 == 3'b101 ? {16'b0, ld_half} : mem_resp_rdata;

  // Handshake and bus outputs; exu_ready drops immediately while reset is asserted
  assign exu_ready      = reset && state_q == S_IDLE;
  assign mem_req_valid  = state_q == S_REQ;
  assign mem_resp_ready = state_q == S_RESP;
  assign rd_valid       = state_q == S_OUT;
  assign mem_req_addr   = {addr_q[31:2], 2'b00};
  assign mem_req_wen    = q_store;
  assign mem_req_wstrb  = !q_store         ? 4'b0000 :
                          q_f3 == 3'b000   ? 4'b0001 << addr_q[1:0] :
                          q_f3 == 3'b001   ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
  assign mem_req_wdata  = q_f3 == 3'b000 ? {4{sdata_q[7:0]}} :
                          q_f3 == 3'b001 ? {2{sdata_q[15:0]}} : sdata_q;

  // Writeback outputs come straight from registers so they hold while rd_ready is low
  assign wdata           = wdata_q;
  assign lsu_to_wbu_inst = inst_q;
  assign next_pc         = npc_q;
  assign num             = num_q;
  assign sim_lsu_addr    = sim_q;
  assign lsu_fault       = fault_q;

  // Next-state and capture logic for the IDLE/REQ/RESP/OUT sequence
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    npc_d   = npc_q;
    num_d   = num_q;
    wdata_d = wdata_q;
    sim_d   = sim_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: if (exu_valid) begin
        inst_d  = exu_inst;
        addr_d  = exu_result;
        sdata_d = exu_store_data;
        npc_d   = exu_next_pc;
        num_d   = exu_num;
        wdata_d = in_mem ? '0 : exu_result;
        sim_d   = in_mem ? exu_result : 32'b0;
        fault_d = fault_q | in_mis;
        state_d = in_mem && !in_mis ? S_REQ : S_OUT;
      end
      S_REQ: state_d = mem_req_ready ? S_RESP : S_REQ;
      S_RESP: if (mem_resp_valid) begin
        wdata_d = q_store ? '0 : load_fmt;
        fault_d = fault_q | mem_resp_err;
        state_d = S_OUT;
      end
      default: state_d = rd_ready ? S_IDLE : S_OUT;
    endcase
  end

  // State registers; reset aborts any outstanding transaction immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      inst_q  <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      npc_q   <= '0;
      num_q   <= '0;
      wdata_q <= '0;
      sim_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      npc_q   <= npc_d;
      num_q   <= num_d;
      wdata_q <= wdata_d;
      sim_q   <= sim_d;
      fault_q <= fault_d;
    end
  end
endmodule

// File: tb/tb_ysyx_24090012_lsu.sv
// tb_ysyx_24090012_lsu: directed self-checking bench for the load/store stage.
module tb_ysyx_24090012_lsu;
  logic        clock = 1'b0;
  logic        reset;
  logic        exu_valid;
  logic        exu_ready;
  logic [31:0] exu_inst, exu_result, exu_store_data, exu_next_pc;
  logic [63:0] exu_num;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0] mem_resp_rdata;
  logic        rd_valid, rd_ready;
  logic [31:0] wdata, lsu_to_wbu_inst, next_pc, sim_lsu_addr;
  logic [63:0] num;
  logic        lsu_fault;
  int          checks = 0;
  int          errors = 0;

  localparam logic [31:0] I_ADD = 32'h00c58533;
  localparam logic [31:0] I_LB  = 32'h00000003;
  localparam logic [31:0] I_LBU = 32'h00004003;
  localparam logic [31:0] I_LW  = 32'h00002003;
  localparam logic [31:0] I_SH  = 32'h00001023;
  localparam logic [31:0] I_SW  = 32'h00002023;

  always #5 clock = ~clock;

  ysyx_24090012_lsu dut (
    .clock(clock), .reset(reset),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_inst(exu_inst),
    .exu_result(exu_result), .exu_store_data(exu_store_data),
    .exu_next_pc(exu_next_pc), .exu_num(exu_num),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .wdata(wdata),
    .lsu_to_wbu_inst(lsu_to_wbu_inst), .next_pc(next_pc), .num(num),
    .sim_lsu_addr(sim_lsu_addr), .lsu_fault(lsu_fault)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one instruction at a falling edge; returns at the falling edge after the handshake.
  task automatic send(input logic [31:0] inst, input logic [31:0] res, input logic [31:0] sd,
                      input logic [31:0] npc, input logic [63:0] n);
    exu_valid = 1'b1; exu_inst = inst; exu_result = res;
    exu_store_data = sd; exu_next_pc = npc; exu_num = n;
    #1 chk("exu_ready_idle", exu_ready, 1'b1);
    @(negedge clock);
    exu_valid = 1'b0;
  endtask

  // Accept the request this cycle, respond the next; returns in OUT.
  task automatic serve(input logic [31:0] rdata, input logic err);
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    chk("resp_ready", mem_resp_ready, 1'b1);
    chk("req_valid_in_resp", mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_rdata = rdata; mem_resp_err = err;
    @(negedge clock);
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
  endtask

  task automatic retire(input string tag, input logic [31:0] exp_w, input logic [63:0] exp_n);
    chk({tag, "_rd_valid"}, rd_valid, 1'b1);
    chk({tag, "_wdata"}, wdata, exp_w);
    chk({tag, "_num"}, num, exp_n);
    rd_ready = 1'b1;
    @(negedge clock);
    chk({tag, "_rd_valid_drop"}, rd_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; exu_valid = 1'b0; exu_inst = '0; exu_result = '0; exu_store_data = '0;
    exu_next_pc = '0; exu_num = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_rdata = '0; mem_resp_err = 1'b0; rd_ready = 1'b1;
    #2;
    chk("rst_exu_ready", exu_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_num", num, 64'h0);
    chk("rst_fault", lsu_fault, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    // Non-memory op passes through in one cycle
    send(I_ADD, 32'h0000_1234, 32'h0, 32'h8000_0004, 64'd1);
    chk("add_sim_addr", sim_lsu_addr, 32'h0);
    chk("add_no_req", mem_req_valid, 1'b0);
    chk("add_inst", lsu_to_wbu_inst, I_ADD);
    chk("add_next_pc", next_pc, 32'h8000_0004);
    chk("add_exu_ready", exu_ready, 1'b0);
    retire("add", 32'h0000_1234, 64'd1);
    chk("add_back_idle", exu_ready, 1'b1);
    // LB / LBU on the top byte lane
    send(I_LB, 32'h8000_0003, 32'h0, 32'h8000_0008, 64'd2);
    chk("lb_req_valid", mem_req_valid, 1'b1);
    chk("lb_addr", mem_req_addr, 32'h8000_0000);
    chk("lb_wen", mem_req_wen, 1'b0);
    chk("lb_wstrb", mem_req_wstrb, 4'b0000);
    serve(32'h8000_0000, 1'b0);
    chk("lb_sim_addr", sim_lsu_addr, 32'h8000_0003);
    retire("lb", 32'hFFFF_FF80, 64'd2);
    send(I_LBU, 32'h8000_0003, 32'h0, 32'h8000_000c, 64'd3);
    serve(32'h8000_0000, 1'b0);
    retire("lbu", 32'h0000_0080, 64'd3);
    // SH on the upper half
    send(I_SH, 32'h8000_0002, 32'hABCD_1234, 32'h8000_0010, 64'd4);
    chk("sh_addr", mem_req_addr, 32'h8000_0000);
    chk("sh_wen", mem_req_wen, 1'b1);
    chk("sh_wstrb", mem_req_wstrb, 4'b1100);
    chk("sh_wdata", mem_req_wdata, 32'h1234_1234);
    serve(32'h0, 1'b0);
    retire("sh", 32'h0, 64'd4);
    // SW with request back-pressure then WBU back-pressure
    send(I_SW, 32'h8000_0010, 32'hDEAD_BEEF, 32'h8000_0014, 64'd5);
    for (int i = 0; i < 3; i++) begin
      chk("sw_hold_req_valid", mem_req_valid, 1'b1);
      chk("sw_hold_addr", mem_req_addr, 32'h8000_0010);
      chk("sw_hold_wdata", mem_req_wdata, 32'hDEAD_BEEF);
      chk("sw_hold_wstrb", mem_req_wstrb, 4'b1111);
      chk("sw_hold_exu_ready", exu_ready, 1'b0);
      @(negedge clock);
    end
    serve(32'h0, 1'b0);
    rd_ready = 1'b0;
    exu_valid = 1'b1; exu_inst = I_ADD; exu_result = 32'h5555_5555; exu_num = 64'd99;
    for (int i = 0; i < 4; i++) begin
      chk("sw_out_rd_valid", rd_valid, 1'b1);
      chk("sw_out_wdata", wdata, 32'h0);
      chk("sw_out_num", num, 64'd5);
      chk("sw_out_sim_addr", sim_lsu_addr, 32'h8000_0010);
      chk("sw_out_exu_ready", exu_ready, 1'b0);
      @(negedge clock);
    end
    exu_valid = 1'b0;
    retire("sw", 32'h0, 64'd5);
    chk("fault_clean", lsu_fault, 1'b0);
    // Misaligned LW faults without bus traffic; fault is sticky
    send(I_LW, 32'h8000_0002, 32'h0, 32'h8000_0018, 64'd6);
    chk("mis_no_req", mem_req_valid, 1'b0);
    chk("mis_fault", lsu_fault, 1'b1);
    chk("mis_sim_addr", sim_lsu_addr, 32'h8000_0002);
    retire("mis", 32'h0, 64'd6);
    send(I_ADD, 32'h0000_0007, 32'h0, 32'h8000_001c, 64'd7);
    retire("after_mis", 32'h0000_0007, 64'd7);
    chk("fault_sticky", lsu_fault, 1'b1);
    // Asynchronous reset while waiting for a response
    send(I_LW, 32'h8000_0004, 32'h0, 32'h8000_0020, 64'd8);
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    chk("pre_rst_resp_ready", mem_resp_ready, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rd_valid", rd_valid, 1'b0);
    chk("mid_rst_req_valid", mem_req_valid, 1'b0);
    chk("mid_rst_resp_ready", mem_resp_ready, 1'b0);
    chk("mid_rst_exu_ready", exu_ready, 1'b0);
    chk("mid_rst_fault", lsu_fault, 1'b0);
    chk("mid_rst_num", num, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("post_rst_exu_ready", exu_ready, 1'b1);
    send(I_ADD, 32'h0000_00AA, 32'h0, 32'h8000_0024, 64'd10);
    retire("b2b_a", 32'h0000_00AA, 64'd10);
    send(I_ADD, 32'h0000_00BB, 32'h0, 32'h8000_0028, 64'd11);
    retire("b2b_b", 32'h0000_00BB, 64'd11);
    // Bus error still retires formatted data and sets the fault
    send(I_LB, 32'h8000_0001, 32'h0, 32'h8000_002c, 64'd12);
    serve(32'h0000_FF00, 1'b1);
    chk("err_fault", lsu_fault, 1'b1);
    retire("err", 32'hFFFF_FFFF, 64'd12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
